sample_scoreboard: RTL and testbench

- Downstream checking stage for the per-circuit benches; sits after the reference and autogen circuits and consumes their outputs.
- Aligns the reference stream to the measured stream, compares signed samples and records mismatch statistics.
- Captures the first failing sample and reports pass/fail once a fixed number of samples has been compared.
- Synthesizable RTL, so it can also be used as an on-chip self-check.

---
 rtl/sample_scoreboard.sv | 132 +++++++++++++
 tb/tb_sample_scoreboard.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_scoreboard.sv
// Compares a measured sample stream against a delay-aligned reference
// stream, keeps mismatch statistics and reports pass/fail after a fixed run.
module sample_scoreboard #(
   parameter int unsigned DATAWIDTH   = 64,
   parameter int unsigned REF_DELAY   = 0,
   parameter int unsigned NUM_SAMPLES = 256,
   parameter int unsigned CNTWIDTH    = 16
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATAWIDTH-1:0] zmeas,
   input  logic [DATAWIDTH-1:0] zref,
   input  logic                 zvalid,
   input  logic                 stop_on_err,
   output logic                 zerr,
   output logic [DATAWIDTH:0]   diff,
   output logic [CNTWIDTH-1:0]  cmp_count,
   output logic [CNTWIDTH-1:0]  err_count,
   output logic [CNTWIDTH-1:0]  first_err_idx,
   output logic [DATAWIDTH-1:0] first_err_meas,
   output logic [DATAWIDTH-1:0] first_err_ref,
   output logic [1:0]           state,
   output logic                 done,
   output logic                 pass
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FAIL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

   state_t cur_state, nxt_state;

   logic [DATAWIDTH-1:0] ref_a;
   logic                 vld_a;
   logic                 cmp_en;
   logic                 mismatch;
   logic                 hit_done;
   logic [CNTWIDTH-1:0]  cmp_inc;
   logic [CNTWIDTH-1:0]  err_inc;
   logic [DATAWIDTH:0]   diff_calc;

   // Reference alignment: zref and zvalid travel together so a sample and
   // its qualifier can never separate.
   generate
      if (REF_DELAY == 0) begin : g_nodly
         assign ref_a = zref;
         assign vld_a = zvalid;
      end else begin : g_dly
         logic [REF_DELAY-1:0][DATAWIDTH-1:0] ref_pipe;
         logic [REF_DELAY-1:0]                vld_pipe;

         always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
               ref_pipe <= '0;
               vld_pipe <= '0;
            end else begin
               ref_pipe[0] <= zref;
               vld_pipe[0] <= zvalid;
               for (int i = 1; i < int'(REF_DELAY); i++) begin
                  ref_pipe[i] <= ref_pipe[i-1];
                  vld_pipe[i] <= vld_pipe[i-1];
               end
            end
         end

         assign ref_a = ref_pipe[REF_DELAY-1];
         assign vld_a = vld_pipe[REF_DELAY-1];
      end
   endgenerate

   assign cmp_en   = vld_a && (cur_state == S_IDLE || cur_state == S_RUN);
   assign mismatch = (zmeas != ref_a);
   assign cmp_inc  = (cmp_count == CNT_MAX) ? cmp_count : cmp_count + CNT_ONE;
   assign err_inc  = (err_count == CNT_MAX) ? err_count : err_count + CNT_ONE;

   // One extra bit of headroom: extremes of opposite sign cannot wrap.
   assign diff_calc = {zmeas[DATAWIDTH-1], zmeas} - {ref_a[DATAWIDTH-1], ref_a};

   // Widen both sides so an unreachable NUM_SAMPLES never aliases onto a count.
   assign hit_done = (64'(cmp_inc) == 64'(NUM_SAMPLES));

   always_comb begin
      nxt_state = cur_state;
      if (cmp_en) begin
         if (mismatch && stop_on_err) nxt_state = S_FAIL;
         else if (hit_done)           nxt_state = S_DONE;
         else                         nxt_state = S_RUN;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) cur_state <= S_IDLE;
      else     cur_state <= nxt_state;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         zerr           <= 1'b0;
         diff           <= '0;
         cmp_count      <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_meas <= '0;
         first_err_ref  <= '0;
      end else begin
         zerr <= cmp_en && mismatch;
         if (cmp_en) begin
            diff      <= diff_calc;
            cmp_count <= cmp_inc;
            if (mismatch) begin
               err_count <= err_inc;
               if (err_count == '0) begin
                  first_err_idx  <= cmp_count;
                  first_err_meas <= zmeas;
                  first_err_ref  <= ref_a;
               end
            end
         end
      end
   end

   assign state = cur_state;
   assign done  = (cur_state == S_FAIL) || (cur_state == S_DONE);
   assign pass  = (cur_state == S_DONE) && (err_count == '0);

endmodule

// File: tb/tb_sample_scoreboard.sv
// Directed bench for sample_scoreboard: several parameterisations share one
// stimulus stream, each checked against hand-computed expectations.
module tb_sample_scoreboard;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [63:0] zmeas = '0;
   logic [63:0] zref = '0;
   logic        zvalid = 1'b0;
   logic        stop_on_err = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   // a: no delay, b: delay 3, c: delay 2, s: 2-bit counters (saturating)
   logic        a_zerr, b_zerr, c_zerr, s_zerr;
   logic [64:0] a_diff, b_diff, c_diff, s_diff;
   logic [15:0] a_cmp, b_cmp, c_cmp;
   logic [15:0] a_err, b_err, c_err;
   logic [15:0] a_fidx, b_fidx, c_fidx;
   logic [1:0]  s_cmp, s_err, s_fidx;
   logic [63:0] a_fmeas, b_fmeas, c_fmeas, s_fmeas;
   logic [63:0] a_fref, b_fref, c_fref, s_fref;
   logic [1:0]  a_state, b_state, c_state, s_state;
   logic        a_done, b_done, c_done, s_done;
   logic        a_pass, b_pass, c_pass, s_pass;

   sample_scoreboard #(.DATAWIDTH(64), .REF_DELAY(0), .NUM_SAMPLES(8), .CNTWIDTH(16)) u_a (
      .Clk(Clk), .Rst(Rst), .zmeas(zmeas), .zref(zref), .zvalid(zvalid), .stop_on_err(stop_on_err),
      .zerr(a_zerr), .diff(a_diff), .cmp_count(a_cmp), .err_count(a_err), .first_err_idx(a_fidx),
      .first_err_meas(a_fmeas), .first_err_ref(a_fref), .state(a_state), .done(a_done), .pass(a_pass));

   sample_scoreboard #(.DATAWIDTH(64), .REF_DELAY(3), .NUM_SAMPLES(8), .CNTWIDTH(16)) u_b (
      .Clk(Clk), .Rst(Rst), .zmeas(zmeas), .zref(zref), .zvalid(zvalid), .stop_on_err(stop_on_err),
      .zerr(b_zerr), .diff(b_diff), .cmp_count(b_cmp), .err_count(b_err), .first_err_idx(b_fidx),
      .first_err_meas(b_fmeas), .first_err_ref(b_fref), .state(b_state), .done(b_done), .pass(b_pass));

   sample_scoreboard #(.DATAWIDTH(64), .REF_DELAY(2), .NUM_SAMPLES(8), .CNTWIDTH(16)) u_c (
      .Clk(Clk), .Rst(Rst), .zmeas(zmeas), .zref(zref), .zvalid(zvalid), .stop_on_err(stop_on_err),
      .zerr(c_zerr), .diff(c_diff), .cmp_count(c_cmp), .err_count(c_err), .first_err_idx(c_fidx),
      .first_err_meas(c_fmeas), .first_err_ref(c_fref), .state(c_state), .done(c_done), .pass(c_pass));

   sample_scoreboard #(.DATAWIDTH(64), .REF_DELAY(0), .NUM_SAMPLES(8), .CNTWIDTH(2)) u_s (
      .Clk(Clk), .Rst(Rst), .zmeas(zmeas), .zref(zref), .zvalid(zvalid), .stop_on_err(stop_on_err),
      .zerr(s_zerr), .diff(s_diff), .cmp_count(s_cmp), .err_count(s_err), .first_err_idx(s_fidx),
      .first_err_meas(s_fmeas), .first_err_ref(s_fref), .state(s_state), .done(s_done), .pass(s_pass));

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] m, input logic [63:0] r, input logic v);
      zmeas  = m;
      zref   = r;
      zvalid = v;
   endtask

   task automatic do_reset();
      drive(64'd0, 64'd0, 1'b0);
      Rst = 1'b1;
      tick();
      tick();
      Rst = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      stop_on_err = 1'b0;
      drive(64'd5, 64'd6, 1'b1);
      tick();
      tick();
      n_tests++;
      if (a_cmp !== 16'd0 || a_err !== 16'd0) begin
         n_fail++; $display("FAIL reset_counts: cmp=%0d err=%0d want 0 0", a_cmp, a_err);
      end
      n_tests++;
      if (a_state !== 2'd0 || a_zerr !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: state=%0d zerr=%b done=%b pass=%b want 0", a_state, a_zerr, a_done, a_pass);
      end
      n_tests++;
      if (a_diff !== 65'd0 || a_fidx !== 16'd0 || a_fmeas !== 64'd0 || a_fref !== 64'd0) begin
         n_fail++; $display("FAIL reset_data: diff=%0h fidx=%0d fmeas=%0h fref=%0h want 0", a_diff, a_fidx, a_fmeas, a_fref);
      end
      Rst = 1'b0;
      drive(64'd0, 64'd0, 1'b0);
   endtask

   task automatic test_identical();
      do_reset();
      stop_on_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(64'(i + 1), 64'(i + 1), 1'b1);
         tick();
         n_tests++;
         if (a_zerr !== 1'b0) begin
            n_fail++; $display("FAIL ident_zerr[%0d]: got %b want 0", i, a_zerr);
         end
         if (i == 0) begin
            n_tests++;
            if (a_state !== 2'd1 || a_cmp !== 16'd1) begin
               n_fail++; $display("FAIL ident_first: state=%0d cmp=%0d want 1 1", a_state, a_cmp);
            end
         end
      end
      n_tests++;
      if (a_cmp !== 16'd8 || a_err !== 16'd0) begin
         n_fail++; $display("FAIL ident_counts: cmp=%0d err=%0d want 8 0", a_cmp, a_err);
      end
      n_tests++;
      if (a_state !== 2'd3 || a_pass !== 1'b1 || a_done !== 1'b1) begin
         n_fail++; $display("FAIL ident_done: state=%0d pass=%b done=%b want 3 1 1", a_state, a_pass, a_done);
      end
      drive(64'd5, 64'd6, 1'b1);
      tick();
      n_tests++;
      if (a_cmp !== 16'd8 || a_zerr !== 1'b0 || a_state !== 2'd3) begin
         n_fail++; $display("FAIL done_frozen: cmp=%0d zerr=%b state=%0d want 8 0 3", a_cmp, a_zerr, a_state);
      end
      drive(64'd0, 64'd0, 1'b0);
   endtask

   task automatic test_single_mismatch();
      do_reset();
      stop_on_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) drive(64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 1'b1);
         else        drive(64'(i + 1), 64'(i + 1), 1'b1);
         tick();
         n_tests++;
         if (i == 4) begin
            if (a_zerr !== 1'b1 || a_diff !== 65'h1_FFFF_FFFF_FFFF_FFF9) begin
               n_fail++; $display("FAIL single_pulse: zerr=%b diff=%0h want 1 1fffffffffffffff9", a_zerr, a_diff);
            end
         end else if (a_zerr !== 1'b0) begin
            n_fail++; $display("FAIL single_zerr[%0d]: got %b want 0", i, a_zerr);
         end
      end
      n_tests++;
      if (a_err !== 16'd1 || a_fidx !== 16'd4) begin
         n_fail++; $display("FAIL single_stats: err=%0d fidx=%0d want 1 4", a_err, a_fidx);
      end
      n_tests++;
      if (a_fmeas !== 64'hFFFF_FFFF_FFFF_FFFD || a_fref !== 64'd4) begin
         n_fail++; $display("FAIL single_capture: meas=%0h ref=%0h want fffffffffffffffd 4", a_fmeas, a_fref);
      end
      n_tests++;
      if (a_state !== 2'd3 || a_pass !== 1'b0 || a_done !== 1'b1) begin
         n_fail++; $display("FAIL single_done: state=%0d pass=%b done=%b want 3 0 1", a_state, a_pass, a_done);
      end
      // 2-bit counters stick at 3, so DONE at 8 is unreachable
      n_tests++;
      if (s_cmp !== 2'd3 || s_err !== 2'd1 || s_fidx !== 2'd3 || s_state !== 2'd1) begin
         n_fail++; $display("FAIL saturate: cmp=%0d err=%0d fidx=%0d state=%0d want 3 1 3 1", s_cmp, s_err, s_fidx, s_state);
      end
      drive(64'd0, 64'd0, 1'b0);
   endtask

   task automatic test_stop_on_err();
      int pulses;
      pulses = 0;
      do_reset();
      stop_on_err = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || i == 5) drive(64'd100, 64'(i + 1), 1'b1);
         else                  drive(64'(i + 1), 64'(i + 1), 1'b1);
         tick();
         if (i == 2) begin
            n_tests++;
            if (a_zerr !== 1'b1 || a_state !== 2'd2 || a_cmp !== 16'd3 || a_err !== 16'd1) begin
               n_fail++; $display("FAIL stop_hit: zerr=%b state=%0d cmp=%0d err=%0d want 1 2 3 1", a_zerr, a_state, a_cmp, a_err);
            end
         end else if (i > 2 && a_zerr === 1'b1) begin
            pulses++;
         end
      end
      n_tests++;
      if (pulses !== 0) begin
         n_fail++; $display("FAIL stop_pulses: got %0d extra zerr pulses want 0", pulses);
      end
      n_tests++;
      if (a_cmp !== 16'd3 || a_err !== 16'd1 || a_fidx !== 16'd2 || a_state !== 2'd2) begin
         n_fail++; $display("FAIL stop_frozen: cmp=%0d err=%0d fidx=%0d state=%0d want 3 1 2 2", a_cmp, a_err, a_fidx, a_state);
      end
      n_tests++;
      if (a_fmeas !== 64'd100 || a_fref !== 64'd3 || a_done !== 1'b1 || a_pass !== 1'b0) begin
         n_fail++; $display("FAIL stop_capture: meas=%0d ref=%0d done=%b pass=%b want 100 3 1 0", a_fmeas, a_fref, a_done, a_pass);
      end
      stop_on_err = 1'b0;
      drive(64'd0, 64'd0, 1'b0);
   endtask

   task automatic test_alignment();
      do_reset();
      stop_on_err = 1'b0;
      for (int t = 0; t < 11; t++) begin
         drive((t >= 3) ? 64'(10 + t - 3) : 64'd0, 64'(10 + t), 1'b1);
         tick();
         if (t < 3) begin
            n_tests++;
            if (b_cmp !== 16'd0) begin
               n_fail++; $display("FAIL align_early[%0d]: cmp=%0d want 0", t, b_cmp);
            end
         end else if (t == 3) begin
            n_tests++;
            if (b_cmp !== 16'd1 || b_zerr !== 1'b0) begin
               n_fail++; $display("FAIL align_first: cmp=%0d zerr=%b want 1 0", b_cmp, b_zerr);
            end
         end
      end
      n_tests++;
      if (b_cmp !== 16'd8 || b_err !== 16'd0 || b_state !== 2'd3 || b_pass !== 1'b1) begin
         n_fail++; $display("FAIL align_d3: cmp=%0d err=%0d state=%0d pass=%b want 8 0 3 1", b_cmp, b_err, b_state, b_pass);
      end
      n_tests++;
      if (c_cmp !== 16'd8 || c_err !== 16'd8 || c_pass !== 1'b0) begin
         n_fail++; $display("FAIL align_d2: cmp=%0d err=%0d pass=%b want 8 8 0", c_cmp, c_err, c_pass);
      end
      drive(64'd0, 64'd0, 1'b0);
   endtask

   task automatic test_overflow();
      do_reset();
      stop_on_err = 1'b0;
      drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1);
      tick();
      n_tests++;
      if (a_diff !== 65'h0_FFFF_FFFF_FFFF_FFFF || a_zerr !== 1'b1) begin
         n_fail++; $display("FAIL ovf_pos: diff=%0h zerr=%b want 0ffffffffffffffff 1", a_diff, a_zerr);
      end
      drive(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      tick();
      n_tests++;
      if (a_diff !== 65'h1_0000_0000_0000_0001) begin
         n_fail++; $display("FAIL ovf_neg: diff=%0h want 10000000000000001", a_diff);
      end
      drive(64'd0, 64'd0, 1'b0);
      tick();
      n_tests++;
      if (a_zerr !== 1'b0 || a_diff !== 65'h1_0000_0000_0000_0001) begin
         n_fail++; $display("FAIL idle_hold: zerr=%b diff=%0h want 0 10000000000000001", a_zerr, a_diff);
      end
   endtask

   task automatic test_fail_beats_done();
      do_reset();
      stop_on_err = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive((i == 7) ? 64'd99 : 64'(i), 64'(i), 1'b1);
         tick();
      end
      n_tests++;
      if (a_state !== 2'd2 || a_cmp !== 16'd8 || a_err !== 16'd1 || a_fidx !== 16'd7) begin
         n_fail++; $display("FAIL last_fail: state=%0d cmp=%0d err=%0d fidx=%0d want 2 8 1 7", a_state, a_cmp, a_err, a_fidx);
      end
      n_tests++;
      if (a_done !== 1'b1 || a_pass !== 1'b0) begin
         n_fail++; $display("FAIL last_flags: done=%b pass=%b want 1 0", a_done, a_pass);
      end
      stop_on_err = 1'b0;
      drive(64'd0, 64'd0, 1'b0);
   endtask

   task automatic test_reset_midrun();
      do_reset();
      stop_on_err = 1'b0;
      drive(64'd1, 64'd1, 1'b1); tick();
      drive(64'd2, 64'd2, 1'b1); tick();
      drive(64'd9, 64'd3, 1'b1); tick();
      n_tests++;
      if (a_cmp !== 16'd3 || a_err !== 16'd1 || a_zerr !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre: cmp=%0d err=%0d zerr=%b want 3 1 1", a_cmp, a_err, a_zerr);
      end
      #2;
      Rst = 1'b1;
      #1;
      n_tests++;
      if (a_cmp !== 16'd0 || a_err !== 16'd0 || a_zerr !== 1'b0 || a_state !== 2'd0) begin
         n_fail++; $display("FAIL mid_async: cmp=%0d err=%0d zerr=%b state=%0d want 0", a_cmp, a_err, a_zerr, a_state);
      end
      n_tests++;
      if (a_diff !== 65'd0 || a_fidx !== 16'd0 || a_fmeas !== 64'd0 || a_fref !== 64'd0) begin
         n_fail++; $display("FAIL mid_async_data: diff=%0h fidx=%0d fmeas=%0h fref=%0h want 0", a_diff, a_fidx, a_fmeas, a_fref);
      end
      #1;
      Rst = 1'b0;
      drive(64'd7, 64'd7, 1'b1); tick();
      drive(64'd8, 64'd8, 1'b1); tick();
      n_tests++;
      if (a_cmp !== 16'd2 || a_err !== 16'd0 || a_state !== 2'd1 || a_fidx !== 16'd0) begin
         n_fail++; $display("FAIL mid_fresh: cmp=%0d err=%0d state=%0d fidx=%0d want 2 0 1 0", a_cmp, a_err, a_state, a_fidx);
      end
      n_tests++;
      if (b_cmp !== 16'd0) begin
         n_fail++; $display("FAIL mid_refill: cmp=%0d want 0", b_cmp);
      end
      drive(64'd0, 64'd0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_identical();
      test_single_mismatch();
      test_stop_on_err();
      test_alignment();
      test_overflow();
      test_fail_beats_done();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
